// File: rtl/lz_normalizer64.sv
// Iterative 64-bit normaliser: left-shifts an operand by its leading-zero count, one count bit per cycle.
// Optional result self-check (out_err) is enabled by defining NORM_CHECK_EN.
module lz_normalizer64 #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CNT_W-1:0]  in_cnt,
  input  logic              in_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_shamt,
`ifdef NORM_CHECK_EN
  output logic              out_err,
`endif
  output logic              out_zero
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [63:0]       data_q, data_d;
  logic [7:0]        shamt_q, shamt_d;
  logic              zero_q, zero_d;
  logic [2:0]        step_q, step_d;
  logic              valid_q, valid_d;
  logic [63:0]       shifted_s;
  logic              accept_s;

  // One barrel stage: shift left by 2^k with zero fill.
  function automatic logic [63:0] shift_step(input logic [63:0] d, input logic [2:0] k);
    case (k)
      3'd0:    return {d[62:0], 1'b0};
      3'd1:    return {d[61:0], 2'b00};
      3'd2:    return {d[59:0], 4'h0};
      3'd3:    return {d[55:0], 8'h00};
      3'd4:    return {d[47:0], 16'h0000};
      3'd5:    return {d[31:0], 32'h0000_0000};
      default: return d;
    endcase
  endfunction

`ifdef NORM_CHECK_EN
  logic lost_q, lost_d;
  logic err_q, err_d;
  logic lost_now_s;

  // Bits that a 2^k stage would push off the top.
  function automatic logic lost_step(input logic [63:0] d, input logic [2:0] k);
    case (k)
      3'd0:    return d[63];
      3'd1:    return |d[63:62];
      3'd2:    return |d[63:60];
      3'd3:    return |d[63:56];
      3'd4:    return |d[63:48];
      3'd5:    return |d[63:32];
      default: return 1'b0;
    endcase
  endfunction
`endif

  assign accept_s  = in_valid && (state_q == ST_IDLE);
  assign shifted_s = shamt_q[step_q] ? shift_step(data_q, step_q) : data_q;

`ifdef NORM_CHECK_EN
  assign lost_now_s = shamt_q[step_q] ? lost_step(data_q, step_q) : 1'b0;
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    shamt_d = shamt_q;
    zero_d  = zero_q;
    step_d  = step_q;
    valid_d = valid_q;
`ifdef NORM_CHECK_EN
    lost_d  = lost_q;
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          // A zero result is forced at capture so the shift steps leave it at 0.
          zero_d  = in_zero | (|in_cnt[7:6]);
          data_d  = zero_d ? 64'h0 : in_data;
          shamt_d = zero_d ? 8'h00 : {2'b00, in_cnt[5:0]};
          step_d  = 3'd5;
          state_d = ST_SHIFT;
`ifdef NORM_CHECK_EN
          lost_d  = 1'b0;
          err_d   = 1'b0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        data_d = shifted_s;
`ifdef NORM_CHECK_EN
        lost_d = lost_q | lost_now_s;
`endif
        if (step_q == 3'd0) begin
          state_d = ST_DONE;
          valid_d = 1'b1;
`ifdef NORM_CHECK_EN
          err_d   = !zero_q && (!shifted_s[63] || lost_q || lost_now_s);
`endif
        end else begin
          step_d = step_q - 3'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= 64'h0;
      shamt_q <= 8'h00;
      zero_q  <= 1'b0;
      step_q  <= 3'd0;
      valid_q <= 1'b0;
`ifdef NORM_CHECK_EN
      lost_q  <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      shamt_q <= shamt_d;
      zero_q  <= zero_d;
      step_q  <= step_d;
      valid_q <= valid_d;
`ifdef NORM_CHECK_EN
      lost_q  <= lost_d;
      err_q   <= err_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_shamt = shamt_q;
  assign out_zero  = zero_q;
`ifdef NORM_CHECK_EN
  assign out_err   = err_q;
`endif

endmodule

// File: tb/tb_lz_normalizer64.sv
// Directed-vector bench for lz_normalizer64; exercises out_err when NORM_CHECK_EN is defined.
module tb_lz_normalizer64;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [7:0]  in_cnt;
  logic        in_zero;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [7:0]  out_shamt;
  logic        out_zero;
`ifdef NORM_CHECK_EN
  logic        out_err;
`endif

  int n_vec;
  int n_err;

  lz_normalizer64 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cnt    (in_cnt),
    .in_zero   (in_zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_shamt (out_shamt),
`ifdef NORM_CHECK_EN
    .out_err   (out_err),
`endif
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int cyc;
    cyc = 0;
    while (in_ready !== 1'b1 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq("in_ready_wait", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [63:0] d, input logic [7:0] c,
                        input logic z, input logic [63:0] exp_d, input logic [7:0] exp_s,
                        input logic exp_z, input logic exp_e, input int hold);
    wait_ready();
    in_valid = 1'b1;
    in_data  = d;
    in_cnt   = c;
    in_zero  = z;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 64'hDEAD_BEEF_DEAD_BEEF;
    in_cnt   = 8'h11;
    check_eq({tag, "_busy"}, {63'd0, in_ready}, 64'd0);
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      #1;
      if (i == 5) check_eq({tag, "_early"}, {63'd0, out_valid}, 64'd0);
    end
    check_eq({tag, "_lat"}, {63'd0, out_valid}, 64'd1);
    check_eq({tag, "_data"}, out_data, exp_d);
    check_eq({tag, "_shamt"}, {56'd0, out_shamt}, {56'd0, exp_s});
    check_eq({tag, "_zero"}, {63'd0, out_zero}, {63'd0, exp_z});
`ifdef NORM_CHECK_EN
    check_eq({tag, "_err"}, {63'd0, out_err}, {63'd0, exp_e});
`else
    if (exp_e) $display("note: %s expects out_err, check logic not built", tag);
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_eq({tag, "_hold"}, out_data, exp_d);
      check_eq({tag, "_hold_v"}, {62'd0, out_valid, in_ready}, 64'd2);
    end
    out_ready = 1'b1;
    check_eq({tag, "_hs_rdy"}, {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq({tag, "_post"}, {62'd0, out_valid, in_ready}, 64'd1);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 64'h0;
    in_cnt    = 8'h00;
    in_zero   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_rdy_vld", {62'd0, out_valid, in_ready}, 64'd1);
    check_eq("rst_data", out_data, 64'h0);
    check_eq("rst_shz", {55'd0, out_zero, out_shamt}, 64'd0);
    rst_n = 1'b1;

    // out_ready while idle has no effect
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq("idle_ordy", {62'd0, out_valid, in_ready}, 64'd1);

    run_op("lsb",   64'h0000_0000_0000_0001, 8'd63, 1'b0, 64'h8000_0000_0000_0000, 8'd63, 1'b0, 1'b0, 0);
    run_op("msb",   64'h8000_0000_0000_0000, 8'd0,  1'b0, 64'h8000_0000_0000_0000, 8'd0,  1'b0, 1'b0, 0);
    run_op("zero",  64'h0,                   8'd0,  1'b1, 64'h0,                   8'd0,  1'b1, 1'b0, 0);
    run_op("cnt64", 64'h0000_1234_0000_0001, 8'h40, 1'b0, 64'h0,                   8'd0,  1'b1, 1'b0, 0);
    run_op("cntC5", 64'h0000_0000_0000_0003, 8'hC5, 1'b0, 64'h0,                   8'd0,  1'b1, 1'b0, 0);
    run_op("bp",    64'h0000_00F0_0000_0000, 8'd24, 1'b0, 64'hF000_0000_0000_0000, 8'd24, 1'b0, 1'b0, 5);
    run_op("c35",   64'h0000_0000_1234_5678, 8'd35, 1'b0, 64'h91A2_B3C0_0000_0000, 8'd35, 1'b0, 1'b0, 1);
    run_op("c52",   64'h0000_0000_0000_0ABC, 8'd52, 1'b0, 64'hABC0_0000_0000_0000, 8'd52, 1'b0, 1'b0, 0);

    // Reset asserted with step 3 pending
    wait_ready();
    in_valid = 1'b1;
    in_data  = 64'h0000_0000_0000_0001;
    in_cnt   = 8'd63;
    in_zero  = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst", {62'd0, out_valid, in_ready}, 64'd1);
    check_eq("mid_rst_data", out_data, 64'h0);
    #3;
    rst_n = 1'b1;
    run_op("after_rst", 64'h0000_0000_0000_0001, 8'd63, 1'b0, 64'h8000_0000_0000_0000, 8'd63, 1'b0, 1'b0, 0);

`ifdef NORM_CHECK_EN
    // 0xFF has 56 leading zeros: 56 is exact, 55 leaves MSB clear, 57 drops a bit
    run_op("chk_ok",   64'h0000_0000_0000_00FF, 8'd56, 1'b0, 64'hFF00_0000_0000_0000, 8'd56, 1'b0, 1'b0, 0);
    run_op("chk_low",  64'h0000_0000_0000_00FF, 8'd55, 1'b0, 64'h7F80_0000_0000_0000, 8'd55, 1'b0, 1'b1, 0);
    run_op("chk_high", 64'h0000_0000_0000_00FF, 8'd57, 1'b0, 64'hFE00_0000_0000_0000, 8'd57, 1'b0, 1'b1, 0);
    run_op("chk_zero", 64'h0,                   8'd0,  1'b1, 64'h0,                   8'd0,  1'b1, 1'b0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
